// File: rtl/title_banner_ctrl_pkg.sv
// Shared state encodings and default geometry for the title banner controller.
package title_banner_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLIDE = 2'd1,
        ST_BLINK = 2'd2,
        ST_HOLD  = 2'd3
    } banner_state_e;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned GLYPH_UNIT = 32;

    // True when the next slide step would reach or pass the resting position.
    function automatic logic slide_arrives(input logic [31:0] x,
                                           input logic [31:0] x_final,
                                           input logic [31:0] step);
        return (x - x_final) <= step;
    endfunction

endpackage

// File: rtl/title_banner_ctrl_frame_counter.sv
// Clear/enable counter that pulses tc on the enable that reaches limit, then wraps to zero.
module title_banner_ctrl_frame_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic        tc
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        tc    = en && !clr && (cnt_q == (limit - 32'd1));
        cnt_d = cnt_q;
        if (clr || tc) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/title_banner_ctrl.sv
// Frame-locked position/visibility sequencer for the title banner: slide in, blink, hold, report done.
// Handshake: start/skip/frame_tick are single-cycle qualifiers sampled at posedge; done is a one-cycle pulse.
module title_banner_ctrl
    import title_banner_ctrl_pkg::*;
#(
    parameter int unsigned X_START       = SCREEN_W,
    parameter int unsigned X_FINAL       = 5 * GLYPH_UNIT,
    parameter int unsigned Y_POS         = 64,
    parameter int unsigned STEP          = GLYPH_UNIT,
    parameter int unsigned BLINK_FRAMES  = 4,
    parameter int unsigned BLINK_TOGGLES = 4,
    parameter int unsigned HOLD_FRAMES   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        skip,
    output logic [31:0] banner_x,
    output logic [31:0] banner_y,
    output logic        visible,
    output logic        busy,
    output logic        done,
    output logic [1:0]  state_dbg
);

    localparam logic [31:0] X_START_C = 32'(X_START);
    localparam logic [31:0] X_FINAL_C = 32'(X_FINAL);
    localparam logic [31:0] STEP_C    = 32'(STEP);
    localparam logic [31:0] BFR_C     = 32'(BLINK_FRAMES);
    localparam logic [31:0] BTG_C     = 32'(BLINK_TOGGLES);
    localparam logic [31:0] HFR_C     = 32'(HOLD_FRAMES);

    banner_state_e state_q, state_d;
    logic [31:0]   x_q, x_d;
    logic [31:0]   tcnt_q, tcnt_d;
    logic          vis_q, vis_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          counting;
    logic          fc_clr;
    logic          fc_en;
    logic [31:0]   fc_limit;
    logic          fc_tc;

    // The frame counter only runs in BLINK/HOLD; a skip wins over the tick and wipes it.
    assign counting = (state_q == ST_BLINK) || (state_q == ST_HOLD);
    assign fc_en    = counting && frame_tick && !skip;
    assign fc_clr   = !counting || skip;
    assign fc_limit = (state_q == ST_BLINK) ? BFR_C : HFR_C;

    title_banner_ctrl_frame_counter u_fcnt (
        .clock (clock),
        .reset (reset),
        .clr   (fc_clr),
        .en    (fc_en),
        .limit (fc_limit),
        .tc    (fc_tc)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tcnt_d  = tcnt_q;
        vis_d   = vis_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SLIDE;
                    x_d     = X_START_C;
                    tcnt_d  = '0;
                    vis_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SLIDE: begin
                if (!skip && frame_tick) begin
                    if (slide_arrives(x_q, X_FINAL_C, STEP_C)) begin
                        x_d     = X_FINAL_C;
                        tcnt_d  = '0;
                        state_d = (BLINK_TOGGLES == 0) ? ST_HOLD : ST_BLINK;
                    end else begin
                        x_d = x_q - STEP_C;
                    end
                end
            end
            ST_BLINK: begin
                if (!skip && fc_tc) begin
                    vis_d  = !vis_q;
                    tcnt_d = tcnt_q + 32'd1;
                    if ((tcnt_q + 32'd1) == BTG_C) begin
                        state_d = ST_HOLD;
                        tcnt_d  = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (!skip && fc_tc) begin
                    state_d = ST_IDLE;
                    x_d     = X_START_C;
                    vis_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (skip && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            x_d     = X_START_C;
            tcnt_d  = '0;
            vis_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            x_q     <= X_START_C;
            tcnt_q  <= '0;
            vis_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tcnt_q  <= tcnt_d;
            vis_q   <= vis_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign banner_x  = x_q;
    assign banner_y  = 32'(Y_POS);
    assign visible   = vis_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
